aoi_bist_sequencer: RTL and testbench
=====================================

# aoi_bist_sequencer

Self-test sequencer for the 4-input AOI gate, o = ~((a1&a2)|(b1&b2)). On a start pulse it drives a1, a2, b1 and b2 through all 16 input combinations and samples the gate output after a settle window. It compares each sample against the AOI truth function and reports a pass flag, a mismatch count and the first failing vector. It sits directly around the AOI gate: its drive outputs feed the gate inputs, and the gate output returns on o_in.

## Interface
- SETTLE_CYCLES, default 1: cycles each vector is held before sampling. Legal range 1..15.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to run a full sweep; honoured only in IDLE
- o_in  input  1  AOI gate output under test
- a1, a2, b1, b2  output  1 each  drive to the gate; {a1,a2,b1,b2} = vec[3:0] (a1 = MSB), registered
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse at end of sweep
- pass  output  1  1 when the last sweep had zero mismatches; held until the next start
- err_count  output  5  mismatch count for the last or current sweep, 0..16
- first_fail_vec  output  4  vec of the first mismatch; 0 when err_count = 0

## Operation
- State machine: IDLE, WAIT, CHECK, DONE.
- Reset values: state = IDLE, vec = 0 (all drives 0), settle counter = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail_vec = 0.
- IDLE, start = 1:
  - vec <= 0, err_count <= 0, first_fail_vec <= 0, pass <= 0, settle counter <= 0.
  - Go to WAIT.
- WAIT:
  - Settle counter increments each cycle.
  - When it equals SETTLE_CYCLES-1, go to CHECK.
  - WAIT therefore lasts exactly SETTLE_CYCLES cycles per vector.
- CHECK (one cycle):
  - expected = ~((vec[3]&vec[2])|(vec[1]&vec[0])).
  - If o_in != expected: err_count <= err_count+1; if err_count == 0, first_fail_vec <= vec.
  - If vec == 15, go to DONE. Otherwise vec <= vec+1, settle counter <= 0, go to WAIT.
- DONE (one cycle):
  - done = 1, pass <= (err_count == 0), vec <= 0.
  - Go to IDLE.
- err_count cannot overflow; 16 is the maximum and fits in 5 bits.
- start is ignored in WAIT, CHECK and DONE; there is no queuing.
- Drives change only on clk edges. The settle window absorbs gate delay.

## Timing
- Start accepted at edge E0. Vector k is driven from edge E0 + k·(SETTLE_CYCLES+1).
- Vector k is sampled in its CHECK cycle, at edge E0 + (k+1)·(SETTLE_CYCLES+1).
- done is high during the cycle after edge E0 + 16·(SETTLE_CYCLES+1).
  - SETTLE_CYCLES = 1: done is high in the 33rd cycle after the start edge.
- busy = 1 in WAIT, CHECK and DONE; busy = 0 in IDLE.
- pass, err_count and first_fail_vec are valid in the cycle done is high, and stay stable until the next accepted start.
- Reset mid-sweep: all outputs return to their reset values immediately, asynchronously. No done pulse. A new start is needed.
- start held high across DONE→IDLE launches a new sweep on the first IDLE cycle.

## Test plan
- Correct AOI model on o_in, SETTLE_CYCLES = 1, start pulse → {a1,a2,b1,b2} steps 0000..1111 every 2 cycles; done pulses 33 cycles after start; pass = 1, err_count = 0, first_fail_vec = 0.
- o_in stuck at 0 → err_count = 9 (vectors where the expected output is 1), first_fail_vec = 0, pass = 0.
- o_in = inverted AOI → err_count = 16, first_fail_vec = 0, pass = 0.
- Correct model except o_in flipped only when vec = 4'b1010 → err_count = 1, first_fail_vec = 4'hA, pass = 0.
- SETTLE_CYCLES = 3 with a gate model of 2-cycle output latency → pass = 1; done pulses 65 cycles after start.
- rst_n pulsed low at vec = 7 → all outputs reset immediately and no done pulse. A second start pulse while busy is ignored: vec sequence unbroken and exactly one done pulse.

Source files
------------

// File: rtl/aoi_bist_sequencer_if.sv
// Signal bundle between the AOI self-test sequencer and its environment (start, gate drives/response, results).
// No flow control: start is a single-cycle request and every result is a level or a one-cycle pulse.
interface aoi_bist_sequencer_if;
  logic       start;
  logic       o_in;
  logic       a1;
  logic       a2;
  logic       b1;
  logic       b2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;

  modport master (
    input  start, o_in,
    output a1, a2, b1, b2, busy, done, pass, err_count, first_fail_vec
  );

  modport slave (
    output start, o_in,
    input  a1, a2, b1, b2, busy, done, pass, err_count, first_fail_vec
  );
endinterface

// File: rtl/aoi_bist_sequencer.sv
// Sweeps the 16 AOI input vectors, holding each SETTLE_CYCLES cycles, then checks o_in for one cycle.
// A sweep takes 16*(SETTLE_CYCLES+1)+1 cycles; start is dropped unless the sequencer is idle.
module aoi_bist_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aoi_bist_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_d;
  logic [3:0] vec, vec_d;
  logic [3:0] settle_cnt, settle_cnt_d;
  logic [4:0] err_count, err_count_d;
  logic [3:0] first_fail, first_fail_d;
  logic       pass_q, pass_d;
  logic       expected;

  assign expected = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= 4'd0;
      settle_cnt <= 4'd0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      pass_q     <= 1'b0;
    end else begin
      state      <= state_d;
      vec        <= vec_d;
      settle_cnt <= settle_cnt_d;
      err_count  <= err_count_d;
      first_fail <= first_fail_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d      = state;
    vec_d        = vec;
    settle_cnt_d = settle_cnt;
    err_count_d  = err_count;
    first_fail_d = first_fail;
    pass_d       = pass_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          vec_d        = 4'd0;
          settle_cnt_d = 4'd0;
          err_count_d  = 5'd0;
          first_fail_d = 4'd0;
          pass_d       = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        settle_cnt_d = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bus.o_in != expected) begin
          err_count_d = err_count + 5'd1;
          if (err_count == 5'd0) begin
            first_fail_d = vec;
          end
        end
        if (vec == 4'd15) begin
          state_d = DONE;
        end else begin
          vec_d        = vec + 4'd1;
          settle_cnt_d = 4'd0;
          state_d      = WAIT;
        end
      end
      DONE: begin
        pass_d  = (err_count == 5'd0);
        vec_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.a1             = vec[3];
  assign bus.a2             = vec[2];
  assign bus.b1             = vec[1];
  assign bus.b2             = vec[0];
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  // The verdict is shown during the done cycle itself, then held by pass_q.
  assign bus.pass           = (state == DONE) ? (err_count == 5'd0) : pass_q;
  assign bus.err_count      = err_count;
  assign bus.first_fail_vec = first_fail;

endmodule

// File: tb/tb_aoi_bist_sequencer.sv
// Drives two sequencers (SETTLE_CYCLES 1 and 3) against table-driven gate models, checked by a sweep-level reference model.
module tb_aoi_bist_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_r [2];
  logic [15:0] resp    [2];
  logic        p1, p2;
  logic [3:0]  drv1, drv3;

  int errors = 0;
  int checks = 0;

  aoi_bist_sequencer_if if1 ();
  aoi_bist_sequencer_if if3 ();

  aoi_bist_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  aoi_bist_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

  assign drv1      = {if1.a1, if1.a2, if1.b1, if1.b2};
  assign drv3      = {if3.a1, if3.a2, if3.b1, if3.b2};
  assign if1.start = start_r[0];
  assign if3.start = start_r[1];
  assign if1.o_in  = resp[0][drv1];
  assign if3.o_in  = p2;

  // Slow gate for the SETTLE_CYCLES=3 instance: response appears two clocks after the drive.
  always @(posedge clk) begin
    p1 <= resp[1][drv3];
    p2 <= p1;
  end

  function automatic logic aoi(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  function automatic logic [15:0] aoi_table();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = aoi(4'(v));
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int w, output logic [3:0] v, output logic bsy, output logic dn,
                        output logic ps, output logic [4:0] ec, output logic [3:0] ff);
    if (w == 0) begin
      v = drv1; bsy = if1.busy; dn = if1.done; ps = if1.pass; ec = if1.err_count; ff = if1.first_fail_vec;
    end else begin
      v = drv3; bsy = if3.busy; dn = if3.done; ps = if3.pass; ec = if3.err_count; ff = if3.first_fail_vec;
    end
  endtask

  task automatic check_reset_state(input int w, input string tag);
    logic [3:0] v, ff;
    logic bsy, dn, ps;
    logic [4:0] ec;
    sample(w, v, bsy, dn, ps, ec, ff);
    chk({tag, "_drv"}, 32'(v), 0);
    chk({tag, "_busy"}, 32'(bsy), 0);
    chk({tag, "_done"}, 32'(dn), 0);
    chk({tag, "_pass"}, 32'(ps), 0);
    chk({tag, "_err"}, 32'(ec), 0);
    chk({tag, "_ff"}, 32'(ff), 0);
  endtask

  // Full sweep; extra_c > 0 injects a second start pulse while busy.
  task automatic run_sweep(input int w, input logic [15:0] r, input int extra_c, input string tag);
    int s, done_c, exp_err, exp_ff, exp_v, vec_bad, busy_bad, done_cnt, done_at;
    logic [3:0] v, ff;
    logic bsy, dn, ps;
    logic [4:0] ec;
    s = (w == 0) ? 1 : 3;
    done_c = 16 * (s + 1) + 1;
    exp_err = 0;
    exp_ff = 0;
    for (int k = 0; k < 16; k++) begin
      if (r[k] !== aoi(4'(k))) begin
        if (exp_err == 0) exp_ff = k;
        exp_err++;
      end
    end
    resp[w] = r;
    vec_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
    @(posedge clk); #1 start_r[w] = 1'b1;
    @(posedge clk); #1 start_r[w] = 1'b0;
    for (int c = 1; c <= done_c + 3; c++) begin
      @(negedge clk);
      sample(w, v, bsy, dn, ps, ec, ff);
      exp_v = (c <= done_c) ? (((c - 1) / (s + 1)) > 15 ? 15 : (c - 1) / (s + 1)) : 0;
      if (32'(v) != 32'(exp_v)) vec_bad++;
      if (bsy !== (c <= done_c)) busy_bad++;
      if (dn === 1'b1) begin
        done_cnt++;
        done_at = c;
        chk({tag, "_pass_at_done"}, 32'(ps), 32'(exp_err == 0));
        chk({tag, "_err_at_done"}, 32'(ec), 32'(exp_err));
        chk({tag, "_ff_at_done"}, 32'(ff), 32'(exp_ff));
      end
      @(posedge clk); #1 start_r[w] = (c == extra_c);
    end
    chk({tag, "_vec_seq"}, 32'(vec_bad), 0);
    chk({tag, "_busy_seq"}, 32'(busy_bad), 0);
    chk({tag, "_done_count"}, 32'(done_cnt), 1);
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(done_c));
    @(negedge clk);
    sample(w, v, bsy, dn, ps, ec, ff);
    chk({tag, "_pass_held"}, 32'(ps), 32'(exp_err == 0));
    chk({tag, "_err_held"}, 32'(ec), 32'(exp_err));
    chk({tag, "_ff_held"}, 32'(ff), 32'(exp_ff));
  endtask

  task automatic reset_mid_sweep();
    logic [3:0] v, ff;
    logic bsy, dn, ps;
    logic [4:0] ec;
    int done_cnt, busy_cnt;
    logic [15:0] r;
    r = aoi_table() ^ 16'h000A;
    resp[0] = r;
    @(posedge clk); #1 start_r[0] = 1'b1;
    @(posedge clk); #1 start_r[0] = 1'b0;
    for (int c = 1; c < 15; c++) @(posedge clk);
    @(negedge clk);
    sample(0, v, bsy, dn, ps, ec, ff);
    chk("rst_pre_vec", 32'(v), 7);
    chk("rst_pre_err", 32'(ec), 2);
    #1 rst_n = 1'b0;
    #1 check_reset_state(0, "rst_async");
    @(posedge clk); #1 rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) done_cnt++;
      if (if1.busy === 1'b1) busy_cnt++;
    end
    chk("rst_no_done", 32'(done_cnt), 0);
    chk("rst_no_busy", 32'(busy_cnt), 0);
  endtask

  initial begin
    logic [15:0] r;
    int w;
    rst_n = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    resp[0] = aoi_table();
    resp[1] = aoi_table();
    repeat (3) @(posedge clk);
    #1 check_reset_state(0, "reset1_in");
    check_reset_state(1, "reset3_in");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state(0, "reset1_out");
    check_reset_state(1, "reset3_out");

    run_sweep(0, aoi_table(), 0, "good_s1");
    run_sweep(0, 16'h0000, 0, "stuck0");
    run_sweep(0, ~aoi_table(), 0, "inverted");
    run_sweep(0, aoi_table() ^ 16'h0400, 0, "flip_a");
    run_sweep(1, aoi_table(), 0, "good_s3");
    run_sweep(0, aoi_table() ^ 16'h0041, 9, "busy_start");
    run_sweep(1, aoi_table() ^ 16'h8000, 20, "busy_start_s3");

    for (int i = 0; i < 6; i++) begin
      w = int'($urandom_range(0, 1));
      r = aoi_table() ^ (16'($urandom) & 16'($urandom));
      if (i == 0) r = aoi_table();
      run_sweep(w, r, 0, "rand");
    end

    reset_mid_sweep();
    run_sweep(0, aoi_table() ^ 16'h0100, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
